multiplier_array_pipe: RTL and testbench
========================================

Name: multiplier_array_pipe

Overview:
Parametrised, pipelined successor to the combinational z-lane fixed-point multiplier set. It multiplies z signed fixed-point operand pairs per transaction, using 1 sign bit, int_bits integer bits and frac = width-1-int_bits fraction bits. Each product is rounded or truncated and then saturated back to width bits. Data moves through a 2-stage valid/ready pipeline with backpressure, and the block keeps sticky per-lane overflow flags plus an overflow event counter. It sits between the weight/activation fetch and the accumulate stage of the DNN datapath.

Parameters:
z, 4, number of parallel lanes (≥1)
width, 12, operand and result width in bits
int_bits, 3, integer bits excluding sign; frac = width-1-int_bits
cnt_width, 16, width of the saturation event counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operands this cycle
a  in  [width-1:0] x z (unpacked)  signed operands A
b  in  [width-1:0] x z (unpacked)  signed operands B
round_en  in  1  1 = round-half-up, 0 = truncate (floor); sampled with operands
out_valid  out  1  result set valid
out_ready  in  1  consumer accepts result
p  out  [width-1:0] x z (unpacked)  signed results
sat_lane  out  [z-1:0]  per-lane sticky "has saturated" flags
sat_count  out  [cnt_width-1:0]  count of saturated lane-results delivered
clear_stats  in  1  synchronous clear of sat_lane and sat_count

Behaviour:
- Reset (async, reset_n=0): both stage valids = 0, out_valid = 0, p = 0, sat_lane = 0, sat_count = 0. in_ready = 1 from the first cycle after reset release.
- Reset asserted mid-transaction drops all in-flight data; no partial result is ever presented.
- Stage 1 (S1): on in_valid && in_ready, register the full 2*width signed product per lane and round_en.
- Stage 2 (S2): register the rounded/saturated results and per-lane sat bits. out_valid = S2 valid.
- Latency: 2 cycles from the accept edge to out_valid, with no stalls.
- Throughput: 1 set/cycle while out_ready = 1.
- Stall rule: S2 loads when !S2.valid || out_ready. S1 advances when S2 loads. in_ready = !S1.valid || S2 load. Bubbles collapse.
- While out_valid && !out_ready, p and out_valid hold stable.
- Arithmetic per lane:
  - raw = a*b, signed, 2*width bits, with 2*frac fraction bits.
  - If round_en, add 2^(frac-1) to raw.
  - Arithmetic-shift right by frac.
  - If the result is > 2^(width-1)-1, output 0x7FF…; if it is < -2^(width-1), output 0x800…; else take the low width bits.
- Ties round toward +inf (half-up on the two's-complement value).
- sat_lane[i] sets when a lane-i result with its sat bit is accepted (out_valid && out_ready). It stays set until clear_stats.
- sat_count adds popcount(sat bits) per accepted set and saturates at all-ones; it never wraps.
- clear_stats in the same cycle as an accepted set: clear wins, and that set's events are dropped.

Decomposition:
- Shared package dnn_fxp_pkg holds:
  - localparam helpers FRAC(width,int_bits), MAX_POS(width), MIN_NEG(width)
  - a typedef for the round mode enum {RND_TRUNC, RND_HALF_UP}
- One combinational sub-module, fxp_round_sat, takes raw product and round_en and produces result and sat. It is instantiated z times in a generate loop between S1 and S2.

Test Plan:
- width=12, int_bits=3, round_en=1, lane0 a=0x001, b=0xABC -> p=0xFFB. Lane1 a=0xFFF, b=0xFFF -> p=0x000. Lane2 a=0x080, b=0x101 -> p=0x081. Lane3 a=0xF80, b=0x0FF -> p=0xF81. out_valid exactly 2 cycles after accept.
- Saturation: a=b=0x7FF -> 0x7FF; a=b=0x800 -> 0x7FF; a=0x800, b=0x7FF -> 0x800. sat_lane bits set and sat_count=3 after the three sets; clear_stats -> both read 0.
- Truncation: round_en=0, a=0x080, b=0x101 -> 0x080; a=0x001, b=0xABC -> 0xFFA.
- Backpressure: stream 6 sets with out_ready low for 3 cycles mid-stream -> in_ready drops when both stages are full, p is stable while stalled, all 6 results arrive in order with none lost or duplicated.
- Reset mid-flight: assert reset_n=0 with both stages valid -> out_valid=0 immediately (async), sat_count=0; the next accepted set appears after 2 cycles.
- Counter saturation: cnt_width=4, push 5 sets of 4 saturating lanes -> sat_count holds 0xF and never wraps.

Source files
------------

// File: rtl/dnn_fxp_pkg.sv
// Shared fixed-point helpers for the DNN datapath: format arithmetic and
// the rounding-mode type.
package dnn_fxp_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  function automatic int unsigned fxp_frac(input int unsigned width,
                                           input int unsigned int_bits);
    return width - 1 - int_bits;
  endfunction

  function automatic longint fxp_max_pos(input int unsigned width);
    return (longint'(1) << (width - 1)) - 1;
  endfunction

  function automatic longint fxp_min_neg(input int unsigned width);
    return -(longint'(1) << (width - 1));
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Rescales a full-precision signed product back to the operand format:
// optional round-half-up, arithmetic shift by frac, then saturation.
module fxp_round_sat
  import dnn_fxp_pkg::*;
#(
  parameter int unsigned width    = 12,
  parameter int unsigned int_bits = 3
) (
  input  logic [2*width-1:0] raw,
  input  logic               round_en,
  output logic [width-1:0]   result,
  output logic               sat
);

  localparam int unsigned FRAC = fxp_frac(width, int_bits);
  localparam int unsigned XW   = 2 * width + 1;
  localparam int unsigned HSH  = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [XW-1:0] HALF = (FRAC > 0) ? (XW'(1) << HSH) : '0;
  localparam logic signed [XW-1:0] MAXV = XW'(fxp_max_pos(width));
  localparam logic signed [XW-1:0] MINV = XW'(fxp_min_neg(width));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shf;

  // One guard bit above the product keeps the rounding add from overflowing.
  always_comb begin
    ext    = {raw[2*width-1], raw};
    rnd    = round_en ? ext + HALF : ext;
    shf    = rnd >>> FRAC;
    result = shf[width-1:0];
    sat    = 1'b0;
    if (shf > MAXV) begin
      result = MAXV[width-1:0];
      sat    = 1'b1;
    end else if (shf < MINV) begin
      result = MINV[width-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/multiplier_array_pipe.sv
// z-lane signed fixed-point multiplier: 2-stage valid/ready pipeline with
// round/saturate, sticky per-lane saturation flags and a saturating event counter.
module multiplier_array_pipe
  import dnn_fxp_pkg::*;
#(
  parameter int unsigned z         = 4,
  parameter int unsigned width     = 12,
  parameter int unsigned int_bits  = 3,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     a [z],
  input  logic [width-1:0]     b [z],
  input  logic                 round_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     p [z],
  output logic [z-1:0]         sat_lane,
  output logic [cnt_width-1:0] sat_count,
  input  logic                 clear_stats
);

  localparam int unsigned PW = cnt_width + $clog2(z + 1);
  localparam logic [PW-1:0] CNT_MAX = PW'({cnt_width{1'b1}});

  logic                 s1_valid_q, s1_valid_d;
  logic [2*width-1:0]   s1_prod_q [z];
  logic [2*width-1:0]   s1_prod_d [z];
  rnd_mode_e            s1_rnd_q, s1_rnd_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [width-1:0]     s2_p_q [z];
  logic [width-1:0]     s2_p_d [z];
  logic [z-1:0]         s2_sat_q, s2_sat_d;
  logic [z-1:0]         sat_lane_q, sat_lane_d;
  logic [cnt_width-1:0] sat_count_q, sat_count_d;

  logic [width-1:0]     rs_result [z];
  logic [z-1:0]         rs_sat;
  logic                 s2_load, accept, deliver;
  logic [PW-1:0]        pop, sum;

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    accept   = in_valid && in_ready;
    deliver  = s2_valid_q && out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rnd_d   = s1_rnd_q;
    s1_prod_d  = s1_prod_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_rnd_d   = round_en ? RND_HALF_UP : RND_TRUNC;
      for (int unsigned i = 0; i < z; i++)
        s1_prod_d[i] = (2*width)'($signed(a[i])) * (2*width)'($signed(b[i]));
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  for (genvar i = 0; i < z; i++) begin : g_lane
    fxp_round_sat #(
      .width    (width),
      .int_bits (int_bits)
    ) u_round_sat (
      .raw      (s1_prod_q[i]),
      .round_en (s1_rnd_q == RND_HALF_UP),
      .result   (rs_result[i]),
      .sat      (rs_sat[i])
    );
  end

  always_comb begin
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_sat_d   = s2_sat_q;
    if (s2_load && s1_valid_q) begin
      s2_p_d   = rs_result;
      s2_sat_d = rs_sat;
    end
  end

  // Clear takes priority over any events delivered in the same cycle.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < z; i++)
      pop = pop + PW'(s2_sat_q[i]);
    sum         = PW'(sat_count_q) + pop;
    sat_lane_d  = sat_lane_q;
    sat_count_d = sat_count_q;
    if (clear_stats) begin
      sat_lane_d  = '0;
      sat_count_d = '0;
    end else if (deliver) begin
      sat_lane_d  = sat_lane_q | s2_sat_q;
      sat_count_d = (sum > CNT_MAX) ? '1 : sum[cnt_width-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_rnd_q    <= RND_TRUNC;
      s2_valid_q  <= 1'b0;
      s2_sat_q    <= '0;
      sat_lane_q  <= '0;
      sat_count_q <= '0;
      for (int unsigned i = 0; i < z; i++) begin
        s1_prod_q[i] <= '0;
        s2_p_q[i]    <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_prod_q   <= s1_prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_p_q      <= s2_p_d;
      s2_sat_q    <= s2_sat_d;
      sat_lane_q  <= sat_lane_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign p         = s2_p_q;
  assign sat_lane  = sat_lane_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_multiplier_array_pipe.sv
// Bench for multiplier_array_pipe: directed vector table, hand sequences for
// stalls/reset/counter limits, and randomized traffic against a scoreboard.
module tb_multiplier_array_pipe;

  localparam int     W    = 12;
  localparam int     FR   = 8;
  localparam longint MAXP = 2047;
  localparam longint MINP = -2048;

  typedef logic [11:0] lane_t [4];
  typedef struct { lane_t p; logic [3:0] sat; } exp_t;
  typedef struct { lane_t a; lane_t b; logic rnd; lane_t e; } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, round_en = 1'b0, clear_stats = 1'b0;
  logic [11:0] a_in [4];
  logic [11:0] b_in [4];
  logic        in_ready, out_valid, in_ready4, out_valid4;
  logic [11:0] p [4];
  logic [11:0] p4 [4];
  logic [3:0]  sat_lane, sat_lane4;
  logic [15:0] sat_count;
  logic [3:0]  sat_count4;

  int total = 0, bad = 0, rx_count = 0;
  exp_t sbq[$];
  logic [3:0] m_lane = '0;
  int m_cnt = 0, m_cnt4 = 0;

  always #5 clk = ~clk;

  multiplier_array_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a_in), .b(b_in), .round_en(round_en), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .sat_lane(sat_lane), .sat_count(sat_count),
    .clear_stats(clear_stats));

  multiplier_array_pipe #(.cnt_width(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a_in), .b(b_in), .round_en(round_en), .out_valid(out_valid4),
    .out_ready(out_ready), .p(p4), .sat_lane(sat_lane4), .sat_count(sat_count4),
    .clear_stats(clear_stats));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: real-valued product scaled by 2^frac, floor after optional +0.5 LSB, clamp.
  function automatic logic [12:0] ref_lane(input logic [11:0] x, input logic [11:0] y,
                                           input logic r);
    longint prod, q;
    prod = longint'($signed(x)) * longint'($signed(y));
    if (r) prod = prod + (longint'(1) << (FR - 1));
    q = prod >>> FR;
    if (q > MAXP) return {1'b1, 12'h7FF};
    if (q < MINP) return {1'b1, 12'h800};
    return {1'b0, 12'(q)};
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    logic [12:0] r;
    for (int i = 0; i < 4; i++) begin
      r = ref_lane(a_in[i], b_in[i], round_en);
      e.p[i] = r[11:0];
      e.sat[i] = r[12];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit dlv, got;
    if (!reset_n) begin
      sbq.delete();
      m_lane = '0;
      m_cnt = 0;
      m_cnt4 = 0;
    end else begin
      got = 0;
      chk("sat_lane", sat_lane, m_lane);
      chk("sat_count", sat_count, m_cnt);
      chk("sat_count_w4", sat_count4, m_cnt4);
      dlv = out_valid && out_ready;
      if (dlv) begin
        chk("sb_has_entry", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          got = 1;
          rx_count++;
          for (int i = 0; i < 4; i++) chk($sformatf("sb_p%0d", i), p[i], e.p[i]);
        end
      end
      if (clear_stats) begin
        m_lane = '0;
        m_cnt = 0;
        m_cnt4 = 0;
      end else if (got) begin
        m_lane = m_lane | e.sat;
        m_cnt = m_cnt + $countones(e.sat);
        if (m_cnt > 65535) m_cnt = 65535;
        m_cnt4 = m_cnt4 + $countones(e.sat);
        if (m_cnt4 > 15) m_cnt4 = 15;
      end
      if (in_valid && in_ready) sbq.push_back(model_now());
    end
  end

  // Single isolated transaction; caller is at posedge+1 with an empty pipeline.
  task automatic run_set(input string nm, input lane_t xa, input lane_t xb,
                         input logic r, input lane_t e);
    a_in = xa; b_in = xb; round_en = r; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk({nm, "_ov_cycle1"}, out_valid, 0);
    @(negedge clk); chk({nm, "_ov_cycle2"}, out_valid, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_p%0d", nm, i), p[i], e[i]);
    @(posedge clk); #1;
  endtask

  task automatic rand_lanes(output lane_t x);
    for (int i = 0; i < 4; i++)
      x[i] = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 12'h7FF : 12'h800)
                                         : 12'($urandom);
  endtask

  vec_t tv[7];
  lane_t bp_a[6], bp_b[6];
  lane_t ra, rb, re;
  lane_t big;
  logic [47:0] prev_p;
  logic [12:0] rl;
  bit prev_stall, saw_full;
  int sent, rx0;

  initial begin
    for (int i = 0; i < 4; i++) begin a_in[i] = '0; b_in[i] = '0; big[i] = 12'h7FF; end
    tv[0] = '{a:'{12'h001,12'hFFF,12'h080,12'hF80}, b:'{12'hABC,12'hFFF,12'h101,12'h0FF}, rnd:1'b1,
              e:'{12'hFFB,12'h000,12'h081,12'hF81}};
    tv[1] = '{a:'{12'h7FF,12'h000,12'h000,12'h000}, b:'{12'h7FF,12'h000,12'h000,12'h000}, rnd:1'b1,
              e:'{12'h7FF,12'h000,12'h000,12'h000}};
    tv[2] = '{a:'{12'h000,12'h800,12'h000,12'h000}, b:'{12'h000,12'h800,12'h000,12'h000}, rnd:1'b1,
              e:'{12'h000,12'h7FF,12'h000,12'h000}};
    tv[3] = '{a:'{12'h000,12'h000,12'h800,12'h000}, b:'{12'h000,12'h000,12'h7FF,12'h000}, rnd:1'b1,
              e:'{12'h000,12'h000,12'h800,12'h000}};
    tv[4] = '{a:'{12'h080,12'h001,12'h7FF,12'h800}, b:'{12'h101,12'hABC,12'h001,12'h001}, rnd:1'b0,
              e:'{12'h080,12'hFFA,12'h007,12'hFF8}};
    tv[5] = '{a:'{12'h080,12'hF80,12'h7FF,12'h800}, b:'{12'h001,12'h001,12'h001,12'h001}, rnd:1'b1,
              e:'{12'h001,12'h000,12'h008,12'hFF8}};
    tv[6] = '{a:'{12'h080,12'hF80,12'h7FF,12'h800}, b:'{12'h001,12'h001,12'h001,12'h001}, rnd:1'b0,
              e:'{12'h000,12'hFFF,12'h007,12'hFF8}};

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat_lane", sat_lane, 0);
    chk("rst_sat_count", sat_count, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_p%0d", i), p[i], 0);
    #20 reset_n = 1'b1;
    @(negedge clk); chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) run_set($sformatf("vec%0d", k), tv[k].a, tv[k].b, tv[k].rnd, tv[k].e);
    @(negedge clk);
    chk("sat_lane_after3", sat_lane, 4'b0111);
    chk("sat_count_after3", sat_count, 3);
    @(posedge clk); #1 clear_stats = 1'b1;
    @(posedge clk); #1 clear_stats = 1'b0;
    @(negedge clk);
    chk("clear_lane", sat_lane, 0);
    chk("clear_count", sat_count, 0);
    @(posedge clk); #1;
    for (int k = 4; k < 7; k++) run_set($sformatf("vec%0d", k), tv[k].a, tv[k].b, tv[k].rnd, tv[k].e);

    // Backpressure: out_ready low for three cycles while a 6-set stream is offered.
    for (int s = 0; s < 6; s++) begin rand_lanes(bp_a[s]); rand_lanes(bp_b[s]); end
    sent = 0; prev_stall = 0; saw_full = 0; rx0 = rx_count; prev_p = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c < 6);
      round_en = 1'b1;
      if (sent < 6) begin in_valid = 1'b1; a_in = bp_a[sent]; b_in = bp_b[sent]; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_ov_hold", out_valid, 1);
        chk("stall_p_hold", {p[3], p[2], p[1], p[0]}, prev_p);
      end
      prev_stall = out_valid && !out_ready;
      prev_p = {p[3], p[2], p[1], p[0]};
      if (in_valid && !in_ready) saw_full = 1;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_sent", sent, 6);
    chk("bp_received", rx_count - rx0, 6);
    chk("bp_in_ready_dropped", saw_full, 1);
    chk("bp_sb_empty", sbq.size(), 0);

    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      round_en = $urandom_range(0, 1);
      clear_stats = ($urandom_range(0, 49) == 0);
      rand_lanes(a_in); rand_lanes(b_in);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
    for (int c = 0; c < 20 && (sbq.size() > 0 || out_valid); c++) begin @(posedge clk); #1; end
    chk("rand_drain_empty", sbq.size(), 0);

    // Counter ceiling: 20 events push the 4-bit counter into its clamp.
    clear_stats = 1'b1;
    @(posedge clk); #1 clear_stats = 1'b0;
    a_in = big; b_in = big; round_en = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("cnt4_clamped", sat_count4, 4'hF);
    chk("cnt16_events", sat_count, 20);
    chk("lanes_all_sat", sat_lane, 4'hF);
    @(posedge clk); #1;

    // clear_stats coincident with a saturating delivery: both counters end at zero.
    a_in = big; b_in = big; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 clear_stats = 1'b1;
    @(posedge clk); #1 clear_stats = 1'b0;
    @(negedge clk);
    chk("clear_wins_count", sat_count, 0);
    chk("clear_wins_lane", sat_lane, 0);
    chk("clear_wins_ov", out_valid, 0);
    @(posedge clk); #1;

    // Reset with both stages occupied.
    run_set("presat", big, big, 1'b1, big);
    a_in = big; b_in = big; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("full_ov", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_count", sat_count, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_ov", out_valid, 0);
    chk("async_rst_count", sat_count, 0);
    chk("async_rst_lane", sat_lane, 0);
    chk("async_rst_p0", p[0], 0);
    @(posedge clk); @(negedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    rand_lanes(ra); rand_lanes(rb);
    for (int i = 0; i < 4; i++) begin rl = ref_lane(ra[i], rb[i], 1'b1); re[i] = rl[11:0]; end
    run_set("after_rst", ra, rb, 1'b1, re);
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    chk("final_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
